uart_rx_ctrl: RTL

//  Controller for the UART receive path of the MIPS32 core. Generates the 16x-oversample

---
 rtl/uart_rx_ctrl_if.sv | 25 ++
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Handshake and register-bus signals between the UART receive controller, the rx
// deserialiser and the processor data bus.
interface uart_rx_ctrl_if;
  logic        tick;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_clear;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport slave (
    input  rx_rdy, rx_data, cs, rd, wr, addr, wdata,
    output tick, rx_clear, rdata, irq
  );

  modport master (
    output rx_rdy, rx_data, cs, rd, wr, addr, wdata,
    input  tick, rx_clear, rdata, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x baud tick, rx handshake capture into a byte FIFO, and a
// 4-word MMIO register file (DATA/STAT/CTRL/COUNT) with a level interrupt.
module uart_rx_ctrl #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_AW = 3
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int unsigned Div   = CLK_HZ / (BAUD * 16) - 1;
  localparam int unsigned CntW  = $clog2(Div + 1);
  localparam int unsigned Depth = 2 ** FIFO_AW;

  localparam logic [CntW-1:0]  DivL   = CntW'(Div);
  localparam logic [FIFO_AW:0] DepthL = (FIFO_AW + 1)'(Depth);

  localparam logic [1:0] StFlush = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StCapt  = 2'd2;
  localparam logic [1:0] StAck   = 2'd3;

  localparam logic [1:0] AddrData  = 2'd0;
  localparam logic [1:0] AddrStat  = 2'd1;
  localparam logic [1:0] AddrCtrl  = 2'd2;
  localparam logic [1:0] AddrCount = 2'd3;

  logic [CntW-1:0]    div_q, div_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               ovr_q, ovr_d;
  logic [1:0]         st_q, st_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [7:0]         mem_q [Depth];

  logic        rd_sel, wr_sel;
  logic        empty, full;
  logic        capt, push, pop, w1c, ctrl_we;
  logic [7:0]  head;
  logic [31:0] rdata;

  // Baud generator: counts 0..Div while enabled, held at 0 otherwise.
  always_comb begin
    div_d = '0;
    if (en_q && (div_q != DivL)) begin
      div_d = div_q + 1'b1;
    end
  end

  assign bus.tick = en_q && (div_q == DivL);

  // Bus decode and FIFO control.
  assign rd_sel  = bus.cs && bus.rd;
  assign wr_sel  = bus.cs && bus.wr;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DepthL);
  assign capt    = (st_q == StCapt);
  assign pop     = rd_sel && (bus.addr == AddrData) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push    = capt && (!full || pop);
  assign w1c     = wr_sel && (bus.addr == AddrStat) && bus.wdata[3];
  assign ctrl_we = wr_sel && (bus.addr == AddrCtrl);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Overrun is sticky; a drop in the same cycle as a W1C wins.
  always_comb begin
    ovr_d = ovr_q;
    if (w1c) begin
      ovr_d = 1'b0;
    end
    if (capt && !push) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    en_d = en_q;
    ie_d = ie_q;
    if (ctrl_we) begin
      en_d = bus.wdata[0];
      ie_d = bus.wdata[1];
    end
  end

  // Capture FSM; FLUSH discards any byte left pending across reset.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StFlush: if (!bus.rx_rdy) st_d = StIdle;
      StIdle:  if (bus.rx_rdy)  st_d = StCapt;
      StCapt:                   st_d = StAck;
      StAck:   if (!bus.rx_rdy) st_d = StIdle;
      default:                  st_d = StFlush;
    endcase
  end

  assign bus.rx_clear = (st_q == StFlush) || (st_q == StAck);

  assign head = empty ? 8'h00 : mem_q[rptr_q];

  always_comb begin
    rdata = '0;
    unique case (bus.addr)
      AddrData:  rdata = {24'b0, head};
      AddrStat:  rdata = {27'b0, full, ovr_q, ie_q, en_q, !empty};
      AddrCtrl:  rdata = {30'b0, ie_q, en_q};
      AddrCount: rdata = 32'(cnt_q);
      default:   rdata = '0;
    endcase
  end

  assign bus.rdata = rdata;
  assign bus.irq   = ie_q && (!empty || ovr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      en_q   <= 1'b1;
      ie_q   <= 1'b0;
      ovr_q  <= 1'b0;
      st_q   <= StFlush;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      ovr_q  <= ovr_d;
      st_q   <= st_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= bus.rx_data;
    end
  end

endmodule
